// File: rtl/tlp_reg_responder.sv
// rtl/tlp_reg_responder.sv - MWr32/MRd32 completer turning host TLPs into register accesses
module tlp_reg_responder #(
    parameter int REG_ABITS = 4
) (
    input  logic                 pcieClk_in,
    input  logic                 pcieRstN_in,
    input  logic [12:0]          cfgBusDev_in,
    input  logic [63:0]          rxData_in,
    input  logic                 rxSOP_in,
    input  logic                 rxEOP_in,
    input  logic                 rxValid_in,
    output logic                 rxReady_out,
    output logic [63:0]          txData_out,
    output logic                 txSOP_out,
    output logic                 txEOP_out,
    output logic                 txValid_out,
    input  logic                 txReady_in,
    output logic [REG_ABITS-1:0] regAddr_out,
    output logic [31:0]          regWrData_out,
    output logic                 regWrEn_out,
    output logic                 regRdEn_out,
    input  logic [31:0]          regRdData_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WDATA, S_DISCARD, S_RDWAIT, S_TX0, S_TX1, S_TX2
    } state_t;

    state_t                state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [15:0]           req_id_q, req_id_d;
    logic [7:0]            tag_q, tag_d;
    logic [6:0]            addr_lo_q, addr_lo_d;
    logic                  rd_phase_q, rd_phase_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic [REG_ABITS-1:0]  reg_addr_q, reg_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [63:0]           tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  tx_sop_q, tx_sop_d;
    logic                  tx_eop_q, tx_eop_d;

    logic                  rx_fire;
    logic                  sop_is_rd, sop_is_wr;
    state_t                sop_state;
    logic [31:0]           cpl_dw1, cpl_dw2;
    logic                  unused_rx;

    assign rxReady_out = !(state_q inside {S_RDWAIT, S_TX0, S_TX1, S_TX2});
    assign rx_fire     = rxValid_in && rxReady_out;
    assign sop_is_rd   = (rxData_in[31:0] == 32'h0000_0001);
    assign sop_is_wr   = (rxData_in[31:0] == 32'h4000_0001);
    // A single-beat unknown TLP is already complete, so skip DISCARD.
    assign sop_state   = (sop_is_rd || sop_is_wr) ? S_HDR : (rxEOP_in ? S_IDLE : S_DISCARD);
    assign cpl_dw1     = {cfgBusDev_in, 3'b000, 3'b000, 1'b0, 12'd4};
    assign cpl_dw2     = {req_id_q, tag_q, 1'b0, addr_lo_q};
    assign unused_rx   = ^rxData_in[39:32];

    assign txData_out    = tx_data_q;
    assign txSOP_out     = tx_sop_q;
    assign txEOP_out     = tx_eop_q;
    assign txValid_out   = tx_valid_q;
    assign regAddr_out   = reg_addr_q;
    assign regWrData_out = wr_data_q;
    assign regWrEn_out   = wr_en_q;
    assign regRdEn_out   = rd_en_q;

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        req_id_d   = req_id_q;
        tag_d      = tag_q;
        addr_lo_d  = addr_lo_q;
        rd_phase_d = rd_phase_q;
        rd_data_d  = rd_data_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_sop_d   = tx_sop_q;
        tx_eop_d   = tx_eop_q;
        case (state_q)
            S_IDLE, S_HDR, S_WDATA, S_DISCARD: begin
                if (rx_fire && rxSOP_in) begin
                    state_d  = sop_state;
                    is_wr_d  = sop_is_wr;
                    req_id_d = rxData_in[63:48];
                    tag_d    = rxData_in[47:40];
                end else if (rx_fire) begin
                    case (state_q)
                        S_HDR: begin
                            reg_addr_d = rxData_in[REG_ABITS+1:2];
                            addr_lo_d  = rxData_in[6:0];
                            if (!is_wr_q) begin
                                rd_en_d    = 1'b1;
                                rd_phase_d = 1'b0;
                                state_d    = S_RDWAIT;
                            end else if (rxData_in[2]) begin
                                wr_data_d = rxData_in[63:32];
                                wr_en_d   = 1'b1;
                                state_d   = S_IDLE;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                        S_WDATA: begin
                            wr_data_d = rxData_in[31:0];
                            wr_en_d   = 1'b1;
                            state_d   = S_IDLE;
                        end
                        S_DISCARD: if (rxEOP_in) state_d = S_IDLE;
                        default: ;
                    endcase
                end
            end
            S_RDWAIT: begin
                // First cycle is the strobe cycle; data is valid the cycle after.
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_data_d  = regRdData_in;
                    tx_data_d  = {cpl_dw1, 32'h4A00_0001};
                    tx_valid_d = 1'b1;
                    tx_sop_d   = 1'b1;
                    tx_eop_d   = 1'b0;
                    state_d    = S_TX0;
                end
            end
            S_TX0: begin
                if (txReady_in) begin
                    tx_sop_d = 1'b0;
                    state_d  = S_TX1;
                    if (addr_lo_q[2]) begin
                        tx_data_d = {rd_data_q, cpl_dw2};
                        tx_eop_d  = 1'b1;
                    end else begin
                        tx_data_d = {32'h0, cpl_dw2};
                    end
                end
            end
            S_TX1: begin
                if (txReady_in) begin
                    if (addr_lo_q[2]) begin
                        tx_valid_d = 1'b0;
                        tx_eop_d   = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = {32'h0, rd_data_q};
                        tx_eop_d  = 1'b1;
                        state_d   = S_TX2;
                    end
                end
            end
            S_TX2: begin
                if (txReady_in) begin
                    tx_valid_d = 1'b0;
                    tx_eop_d   = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pcieClk_in) begin
        if (!pcieRstN_in) begin
            state_q    <= S_IDLE;
            is_wr_q    <= 1'b0;
            req_id_q   <= '0;
            tag_q      <= '0;
            addr_lo_q  <= '0;
            rd_phase_q <= 1'b0;
            rd_data_q  <= '0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            req_id_q   <= req_id_d;
            tag_q      <= tag_d;
            addr_lo_q  <= addr_lo_d;
            rd_phase_q <= rd_phase_d;
            rd_data_q  <= rd_data_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_sop_q   <= tx_sop_d;
            tx_eop_q   <= tx_eop_d;
        end
    end

endmodule

// File: tb/tb_tlp_reg_responder.sv
// tb/tb_tlp_reg_responder.sv - table, directed and random checks of tlp_reg_responder
module tb_tlp_reg_responder;

    localparam int REG_ABITS = 4;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [12:0]          cfg;
    logic [63:0]          rx_data;
    logic                 rx_sop, rx_eop, rx_valid;
    logic                 rxReady_out;
    logic [63:0]          txData_out;
    logic                 txSOP_out, txEOP_out, txValid_out;
    logic                 txReady_in;
    logic [REG_ABITS-1:0] regAddr_out;
    logic [31:0]          regWrData_out;
    logic                 regWrEn_out, regRdEn_out;
    logic [31:0]          regRdData_in;

    always #5 clk = ~clk;

    tlp_reg_responder #(.REG_ABITS(REG_ABITS)) dut (
        .pcieClk_in    (clk),
        .pcieRstN_in   (rstn),
        .cfgBusDev_in  (cfg),
        .rxData_in     (rx_data),
        .rxSOP_in      (rx_sop),
        .rxEOP_in      (rx_eop),
        .rxValid_in    (rx_valid),
        .rxReady_out   (rxReady_out),
        .txData_out    (txData_out),
        .txSOP_out     (txSOP_out),
        .txEOP_out     (txEOP_out),
        .txValid_out   (txValid_out),
        .txReady_in    (txReady_in),
        .regAddr_out   (regAddr_out),
        .regWrData_out (regWrData_out),
        .regWrEn_out   (regWrEn_out),
        .regRdEn_out   (regRdEn_out),
        .regRdData_in  (regRdData_in)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] reg_init(input int i);
        case (i)
            2:       return 32'hDEADBEEF;
            3:       return 32'h12345678;
            default: return 32'hA5A50000 | 32'(i);
        endcase
    endfunction

    // Register file with a one-cycle registered read.
    logic [31:0] regs [16];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) regs[i] <= reg_init(i);
            rd_q <= '0;
        end else begin
            if (regWrEn_out) regs[regAddr_out] <= regWrData_out;
            if (regRdEn_out) rd_q <= regs[regAddr_out];
        end
    end
    assign regRdData_in = rd_q;

    // Reference model: expected register contents, writes and completion beats.
    logic [31:0] mregs [16];
    logic [65:0] exp_tx [$];
    logic [35:0] exp_wr [$];

    function automatic void push_rd(input logic [31:0] dw1, input logic [31:0] addr);
        logic [3:0]  idx = 4'((addr >> 2) & 32'hF);
        logic [31:0] d   = mregs[idx];
        logic [31:0] h1  = (32'(cfg) << 19) | 32'd4;
        logic [31:0] h2  = (dw1 & 32'hFFFFFF00) | (addr & 32'h7F);
        exp_tx.push_back({2'b10, h1, 32'h4A000001});
        if (((addr >> 2) & 32'h1) != 0) begin
            exp_tx.push_back({2'b01, d, h2});
        end else begin
            exp_tx.push_back({2'b00, 32'h0, h2});
            exp_tx.push_back({2'b01, 32'h0, d});
        end
    endfunction

    function automatic void push_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [3:0] idx = 4'((addr >> 2) & 32'hF);
        mregs[idx] = data;
        exp_wr.push_back({idx, data});
    endfunction

    int tx_mode = 0;
    bit sb_en   = 1'b0;

    // txReady driver: 0 always-ready, 1 random, 2 pattern 1,0,0,1, 3 never-ready.
    initial begin
        int pat_i = 0;
        txReady_in = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (tx_mode)
                0: txReady_in = 1'b1;
                1: txReady_in = 1'($urandom_range(0, 1));
                2: begin
                    txReady_in = (pat_i == 0) || (pat_i == 3);
                    pat_i = (pat_i + 1) % 4;
                end
                default: txReady_in = 1'b0;
            endcase
        end
    end

    // Mid-cycle monitor: scoreboard, hold-while-stalled, back-pressure, strobe exclusivity.
    initial begin
        logic [65:0] e;
        logic [35:0] w;
        logic [65:0] prev_beat = '0;
        bit          prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                if (prev_stall)
                    check(txValid_out && ({txSOP_out, txEOP_out, txData_out} == prev_beat), "tx_hold",
                          {txSOP_out, txEOP_out, txData_out}, prev_beat);
                if (txValid_out && txReady_in) begin
                    if (exp_tx.size() == 0) check(1'b0, "tx_unexpected", {txSOP_out, txEOP_out, txData_out}, '0);
                    else begin
                        e = exp_tx.pop_front();
                        check({txSOP_out, txEOP_out, txData_out} == e, "tx_beat", {txSOP_out, txEOP_out, txData_out}, e);
                    end
                end
                if (regWrEn_out) begin
                    if (exp_wr.size() == 0) check(1'b0, "wr_unexpected", {regAddr_out, regWrData_out}, '0);
                    else begin
                        w = exp_wr.pop_front();
                        check({regAddr_out, regWrData_out} == w, "wr_strobe", {regAddr_out, regWrData_out}, w);
                    end
                end
                if (txValid_out) check(!rxReady_out, "rx_backpressure", rxReady_out, 0);
                if (regWrEn_out && regRdEn_out) check(1'b0, "strobe_overlap", 1, 0);
                prev_stall = txValid_out && !txReady_in;
                prev_beat  = {txSOP_out, txEOP_out, txData_out};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input bit sop, input bit eop, input int gap);
        int n   = 0;
        bit acc = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) step();
        rx_data  = d;
        rx_sop   = sop;
        rx_eop   = eop;
        rx_valid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = rxReady_out;
            step();
            n++;
        end
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
        if (!acc) check(1'b0, "rx_accept_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || txValid_out) && n < 400) begin
            step();
            n++;
        end
        check(exp_tx.size() == 0 && exp_wr.size() == 0, name, 66'(exp_tx.size() + exp_wr.size()), 0);
    endtask

    typedef struct {
        logic [3:0][63:0] beat;
        int               nbeats;
        int               txmode;
        int               n_tx;
        logic [2:0][63:0] tx;
        bit               wr;
        logic [3:0]       wr_idx;
        logic [31:0]      wr_data;
    } vec_t;

    function automatic vec_t mk(input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] b2,
                                input logic [63:0] b3, input int nb, input int md, input int ntx,
                                input logic [63:0] t0, input logic [63:0] t1, input logic [63:0] t2,
                                input bit wr, input logic [3:0] idx, input logic [31:0] wd);
        vec_t v;
        v.beat[0] = b0; v.beat[1] = b1; v.beat[2] = b2; v.beat[3] = b3;
        v.nbeats  = nb;
        v.txmode  = md;
        v.n_tx    = ntx;
        v.tx[0] = t0; v.tx[1] = t1; v.tx[2] = t2;
        v.wr      = wr;
        v.wr_idx  = idx;
        v.wr_data = wd;
        return v;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [8];
        logic [31:0] dw1, addr, wd, r, dw0;
        int          kind, g, nb, cnt;
        bit          pp, saw;

        rstn = 1'b0; cfg = 13'h0101;
        rx_data = '0; rx_sop = 1'b0; rx_eop = 1'b0; rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) mregs[i] = reg_init(i);
        repeat (3) step();

        check(rxReady_out == 1'b1, "rst_rxready", rxReady_out, 1);
        check({txValid_out, txSOP_out, txEOP_out} == 3'b000, "rst_tx_flags", {txValid_out, txSOP_out, txEOP_out}, 0);
        check({regWrEn_out, regRdEn_out} == 2'b00, "rst_strobes", {regWrEn_out, regRdEn_out}, 0);
        check(txData_out == 64'h0, "rst_txdata", txData_out, 0);
        check({regAddr_out, regWrData_out} == 36'h0, "rst_reg_port", {regAddr_out, regWrData_out}, 0);

        rstn  = 1'b1;
        sb_en = 1'b1;
        step();

        vt[0] = mk(64'h01000500_00000001, 64'h00000000_F0000008, 64'h0, 64'h0, 2, 0, 3,
                   64'h08080004_4A000001, 64'h00000000_01000508, 64'h00000000_DEADBEEF, 0, 4'd0, 32'h0);
        vt[1] = mk(64'h01000500_00000001, 64'h00000000_F000000C, 64'h0, 64'h0, 2, 0, 2,
                   64'h08080004_4A000001, 64'h12345678_0100050C, 64'h0, 0, 4'd0, 32'h0);
        vt[2] = mk(64'h01000500_40000001, 64'hCAFEF00D_00000004, 64'h0, 64'h0, 2, 0, 0,
                   64'h0, 64'h0, 64'h0, 1, 4'd1, 32'hCAFEF00D);
        vt[3] = mk(64'h01000500_40000001, 64'h00000000_00000008, 64'h00000000_00000055, 64'h0, 3, 0, 0,
                   64'h0, 64'h0, 64'h0, 1, 4'd2, 32'h00000055);
        vt[4] = mk(64'h01000500_40000002, 64'h00000000_00000008, 64'h00000000_11111111,
                   64'h00000000_22222222, 4, 0, 0, 64'h0, 64'h0, 64'h0, 0, 4'd0, 32'h0);
        vt[5] = mk(64'hABCD7700_00000001, 64'h00000000_F0000008, 64'h0, 64'h0, 2, 0, 3,
                   64'h08080004_4A000001, 64'h00000000_ABCD7708, 64'h00000000_00000055, 0, 4'd0, 32'h0);
        vt[6] = mk(64'hABCD7700_00000001, 64'h00000000_00000004, 64'h0, 64'h0, 2, 0, 2,
                   64'h08080004_4A000001, 64'hCAFEF00D_ABCD7704, 64'h0, 0, 4'd0, 32'h0);
        vt[7] = mk(64'h01000500_00000001, 64'h00000000_F0000008, 64'h0, 64'h0, 2, 2, 3,
                   64'h08080004_4A000001, 64'h00000000_01000508, 64'h00000000_00000055, 0, 4'd0, 32'h0);

        for (int v = 0; v < 8; v++) begin
            tx_mode = vt[v].txmode;
            for (int k = 0; k < vt[v].n_tx; k++)
                exp_tx.push_back({k == 0, k == vt[v].n_tx - 1, vt[v].tx[k]});
            if (vt[v].wr) begin
                exp_wr.push_back({vt[v].wr_idx, vt[v].wr_data});
                mregs[vt[v].wr_idx] = vt[v].wr_data;
            end
            for (int b = 0; b < vt[v].nbeats; b++)
                send_beat(vt[v].beat[b], b == 0, b == vt[v].nbeats - 1, 0);
            drain($sformatf("table_row%0d", v));
        end
        tx_mode = 0;

        // Write strobe appears the cycle after beat1 and lasts one cycle.
        push_wr(32'h00000014, 32'h0BADF00D);
        send_beat({32'h11112200, 32'h40000001}, 1, 0, 0);
        send_beat({32'h0BADF00D, 32'h00000014}, 0, 1, 0);
        check(regWrEn_out && regAddr_out == 4'd5 && regWrData_out == 32'h0BADF00D, "wr_timing",
              {regWrEn_out, regAddr_out, regWrData_out}, {1'b1, 4'd5, 32'h0BADF00D});
        step();
        check(!regWrEn_out && !txValid_out, "wr_pulse_end", {regWrEn_out, txValid_out}, 0);
        drain("wr_directed");

        // Read strobe with the beat1 acceptance edge, completion two cycles later.
        push_rd(32'h5A5A3C00, 32'h00000024);
        send_beat({32'h5A5A3C00, 32'h00000001}, 1, 0, 0);
        send_beat({32'h0, 32'h00000024}, 0, 1, 0);
        check(regRdEn_out && regAddr_out == 4'd9, "rd_strobe", {regRdEn_out, regAddr_out}, {1'b1, 4'd9});
        step();
        check(!regRdEn_out && !txValid_out, "rd_wait", {regRdEn_out, txValid_out}, 0);
        step();
        check(txValid_out && txSOP_out, "cpl_latency", {txValid_out, txSOP_out}, 2'b11);
        drain("rd_directed");

        // Randomised traffic against the reference model.
        tx_mode = 1;
        pp = 1'b0;
        for (int b = 0; b < 4; b++) begin
            cfg = 13'($urandom);
            for (int t = 0; t < 25; t++) begin
                kind = $urandom_range(0, 4);
                dw1 = $urandom; addr = $urandom; wd = $urandom; r = $urandom;
                g = $urandom_range(0, 2);
                case (kind)
                    0: begin
                        push_rd(dw1, addr);
                        send_beat({dw1, 32'h00000001}, 1, 0, g);
                        send_beat({r, addr}, 0, 1, g);
                        pp = 1'b0;
                    end
                    1: begin
                        push_wr(addr, wd);
                        send_beat({dw1, 32'h40000001}, 1, 0, g);
                        if (addr[2]) send_beat({wd, addr}, 0, 1, g);
                        else begin
                            send_beat({r, addr}, 0, 0, g);
                            send_beat({r, wd}, 0, 1, g);
                        end
                        pp = 1'b0;
                    end
                    2: begin
                        dw0 = $urandom;
                        if (dw0 == 32'h00000001 || dw0 == 32'h40000001) dw0 = dw0 ^ 32'h10;
                        nb = $urandom_range(1, 4);
                        for (int k = 0; k < nb; k++)
                            send_beat((k == 0) ? {dw1, dw0} : {r, wd ^ 32'(k)}, k == 0, k == nb - 1, g);
                        pp = 1'b0;
                    end
                    3: begin
                        if (wd[0]) send_beat({dw1, (wd[1] ? 32'h00000001 : 32'h40000001)}, 1, 0, g);
                        else begin
                            send_beat({dw1, 32'h40000001}, 1, 0, g);
                            send_beat({r, addr & ~32'h4}, 0, 0, g);
                        end
                        pp = 1'b1;
                    end
                    default: if (!pp) send_beat({r, wd}, 0, wd[3], g);
                endcase
            end
            drain($sformatf("random_batch%0d", b));
        end

        // Reset while the second completion beat is stalled.
        sb_en   = 1'b0;
        tx_mode = 3;
        cfg     = 13'h0101;
        send_beat({32'h01000500, 32'h00000001}, 1, 0, 0);
        send_beat({32'h0, 32'h00000008}, 0, 1, 0);
        cnt = 0;
        while (!txValid_out && cnt < 20) begin step(); cnt++; end
        check(txValid_out && txSOP_out, "abort_tx0_seen", {txValid_out, txSOP_out}, 2'b11);
        tx_mode = 0;
        step();
        tx_mode = 3;
        check(txValid_out && !txSOP_out && txData_out == 64'h00000000_01000508, "abort_in_tx1",
              {txValid_out, txSOP_out, txData_out}, {1'b1, 1'b0, 64'h00000000_01000508});
        rstn = 1'b0;
        step();
        check({txValid_out, txSOP_out, txEOP_out, regWrEn_out, regRdEn_out} == 5'b0, "abort_rst_flags",
              {txValid_out, txSOP_out, txEOP_out, regWrEn_out, regRdEn_out}, 0);
        check(txData_out == 64'h0 && regAddr_out == 4'd0 && regWrData_out == 32'h0 && rxReady_out,
              "abort_rst_data", {txData_out[31:0], regAddr_out, regWrData_out[27:0], rxReady_out}, 1);
        rstn    = 1'b1;
        tx_mode = 0;
        saw     = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (txValid_out) saw = 1'b1;
        end
        check(!saw, "abort_no_more_tx", saw, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tlp_reg_responder.md
Name: tlp_reg_responder

Overview:
- Target-side completer on the 64-bit TLP pipes of the PCIe hard-IP wrapper.
- Accepts host MWr32 and MRd32 requests (1 DW each) from the Host->FPGA pipe and turns them into register writes and reads.
- Returns a CplD for every MRd32 on the FPGA->Host pipe.
- Sits inside the application layer as its register-access front end.

Parameters:
- REG_ABITS, 4: register index width. Register space is 2^REG_ABITS 32-bit registers. Index = TLP address[REG_ABITS+1:2]; upper address bits are ignored (BAR decode is done upstream).

Ports:
- pcieClk_in  in  1: sole clock, rising edge.
- pcieRstN_in  in  1: synchronous, active-low reset.
- cfgBusDev_in  in  13: bus/device number; completer ID = {cfgBusDev_in, 3'b000}.
- rxData_in  in  64: Host->FPGA TLP beat. Earlier DW is in [31:0].
- rxSOP_in  in  1: first beat of a TLP.
- rxEOP_in  in  1: last beat of a TLP.
- rxValid_in  in  1: beat valid.
- rxReady_out  out  1: beat accepted when rxValid_in && rxReady_out.
- txData_out  out  64: FPGA->Host TLP beat.
- txSOP_out  out  1: first beat of the completion.
- txEOP_out  out  1: last beat of the completion.
- txValid_out  out  1: beat valid.
- txReady_in  in  1: beat consumed when txValid_out && txReady_in.
- regAddr_out  out  REG_ABITS: register index.
- regWrData_out  out  32: write data.
- regWrEn_out  out  1: one-cycle write strobe.
- regRdEn_out  out  1: one-cycle read strobe.
- regRdData_in  in  32: read data, sampled exactly 1 cycle after regRdEn_out.

Behaviour:
- Reset (pcieRstN_in=0 at an edge): state=IDLE; rxReady_out=1; txValid_out, txSOP_out, txEOP_out, regWrEn_out, regRdEn_out = 0; txData_out, regAddr_out, regWrData_out = 0.
- Reset mid-TLP or mid-completion aborts it. No further tx beats are emitted.
- Rx beat format: beat0 = {DW1, DW0}; beat1[31:0] = DW2 (address).
  - Write data is in beat1[63:32] when address[2]=1.
  - Write data is in beat2[31:0] when address[2]=0.
- Decode on beat0 (SOP):
  - DW0 = 32'h00000001 -> MRd32.
  - DW0 = 32'h40000001 -> MWr32.
  - Anything else -> DISCARD.
  - Latch requester ID = DW1[31:16] and tag = DW1[15:8].
- States:
  - IDLE: wait for an accepted SOP beat, go to HDR.
  - HDR: accept beat1 and latch the address.
    - MWr32 with addr[2]=1: pulse regWrEn_out the next cycle, go to IDLE.
    - MWr32 with addr[2]=0: go to WDATA.
    - MRd32: pulse regRdEn_out, go to RDWAIT.
  - WDATA: accept beat2, pulse regWrEn_out, go to IDLE.
  - DISCARD: rxReady_out=1; drop beats up to and including EOP, go to IDLE.
  - RDWAIT: capture regRdData_in, go to TX0.
  - TX0 / TX1 / TX2: drive completion beats.
- rxReady_out = 0 in RDWAIT and TX* states (back-pressure); 1 otherwise.
- A non-SOP beat in IDLE is dropped.
- SOP before an expected EOP: the current TLP is abandoned and the new one is decoded.
- Completion beats:
  - beat0 = {DW1, 32'h4A000001}, where DW1 = {cfgBusDev_in, 3'b000, 3'b000 (SC), 1'b0, 12'd4}.
  - DW2 = {reqID, tag, 1'b0, addr[6:0]}.
  - addr[2]=1: beat1 = {rdData, DW2} with EOP; 2 beats total.
  - addr[2]=0: beat1 = {32'h0, DW2}, then beat2 = {32'h0, rdData} with EOP; 3 beats total.
- Tx handshake: each beat is held stable with txValid_out=1 until txReady_in. txReady_in may drop at any beat.
- Completion start: txValid_out rises 2 cycles after the MRd32 beat1 is accepted.
- Only one request is outstanding. No new rx beat is accepted until the final completion beat is consumed.
- regWrEn_out and regRdEn_out are never asserted together.
- regAddr_out is stable during both strobes.

Test Plan:
- Set cfgBusDev=13'h0101 and reg2=32'hDEADBEEF. Send MRd32 with DW1=32'h01000500 and addr=32'hF0000008. Expect a 3-beat completion: {32'h08080004,32'h4A000001}, {32'h0,32'h01000508}, {32'h0,32'hDEADBEEF} with EOP.
- Send MRd32 with addr=32'hF000000C and reg3=32'h12345678. Expect 2 beats; beat1 = {32'h12345678, 32'h0100050C} with EOP.
- Send MWr32 to addr 32'h4 (beat1 = {32'hCAFEF00D, 32'h4}). Expect a single regWrEn_out with regAddr=1 and data=32'hCAFEF00D; no tx activity.
- Send MWr32 to addr 32'h8 with data in beat2 = 32'h00000055. Expect regWrEn_out on the cycle after beat2 is accepted, regAddr=2.
- Run the MRd32 case with txReady_in toggled 1,0,0,1 each cycle. Expect beats held unchanged while stalled, rxReady_out=0 throughout, and no duplicated or lost beats.
- Send a 4-beat MWr with length=2 (DW0=32'h40000002), followed immediately by an MRd32. Expect the first TLP discarded with no strobe, then a correct completion for the MRd32. Then assert reset mid-TX1 and expect all outputs at reset values on the next cycle.
